// File: rtl/add_res_buf.sv
// rtl/add_res_buf.sv - FP adder result buffer with class tagging and sticky overflow

// Classifies an FP value from its exponent and mantissa; bit order {nan,inf,sub,zero}.
module add_res_cls #(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [EXPO_W-1:0] expo,
  input  logic [MANT_W-1:0] mant,
  output logic [3:0]        cls
);

  // Zero/subnormal share an all-zero exponent; inf/NaN share an all-ones exponent.
  always_comb begin
    cls = 4'b0000;
    if (expo == '0) begin
      if (mant == '0) cls[0] = 1'b1;
      else            cls[1] = 1'b1;
    end else if (&expo) begin
      if (mant == '0) cls[2] = 1'b1;
      else            cls[3] = 1'b1;
    end
  end

endmodule

// Result FIFO behind the adder; the adder cannot stall, so refused pushes set ovf.
module add_res_buf #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int DEPTH  = 4,
  parameter int FP_W   = SIGN_W + EXPO_W + MANT_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [FP_W-1:0]  in_res,
  output logic             in_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [FP_W-1:0]  out_res,
  output logic [3:0]       out_cls,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = FP_W + 4;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             push;
  logic             pop;
  logic             drop;
  logic [3:0]       in_cls;
  logic [ENT_W-1:0] head;

  add_res_cls #(
    .EXPO_W(EXPO_W),
    .MANT_W(MANT_W)
  ) u_cls (
    .expo(in_res[MANT_W +: EXPO_W]),
    .mant(in_res[MANT_W-1:0]),
    .cls (in_cls)
  );

  // Handshake decode; full refuses a push even when a pop frees a slot this cycle.
  always_comb begin
    in_rdy  = (cnt_q != CNT_W'(DEPTH));
    out_vld = (cnt_q != '0);
    push    = in_vld & in_rdy;
    pop     = out_vld & out_rdy;
    drop    = in_vld & ~in_rdy;
  end

  // Next-state for storage, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_res, in_cls};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // A fresh drop takes priority over a clear in the same cycle.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because out_vld gates them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head read is combinational and zeroed when the FIFO is empty.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    out_res = out_vld ? head[ENT_W-1:4] : '0;
    out_cls = out_vld ? head[3:0] : 4'b0000;
    cnt     = cnt_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_add_res_buf.sv
// tb/tb_add_res_buf.sv - directed bench for add_res_buf

module tb_add_res_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic [31:0] in_res;
  logic        in_rdy;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_res;
  logic [3:0]  out_cls;
  logic [2:0]  cnt;
  logic        ovf;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];

  add_res_buf dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (in_vld),
    .in_res (in_res),
    .in_rdy (in_rdy),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_res(out_res),
    .out_cls(out_cls),
    .cnt    (cnt),
    .ovf    (ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; in_res = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_cmp++; if (cnt !== 3'd0) begin $display("FAIL reset_cnt got %0d want 0", cnt); n_err++; end
    n_cmp++; if (out_vld !== 1'b0) begin $display("FAIL reset_out_vld got %b want 0", out_vld); n_err++; end
    n_cmp++; if (in_rdy !== 1'b1) begin $display("FAIL reset_in_rdy got %b want 1", in_rdy); n_err++; end
    n_cmp++; if (ovf !== 1'b0) begin $display("FAIL reset_ovf got %b want 0", ovf); n_err++; end
    n_cmp++; if (out_res !== 32'h0) begin $display("FAIL reset_out_res got %h want 0", out_res); n_err++; end
  endtask

  task automatic test_single_push();
    in_vld = 1'b1; in_res = 32'h3F80_0000;
    step();
    in_vld = 1'b0;
    n_cmp++; if (out_vld !== 1'b1) begin $display("FAIL single_out_vld got %b want 1", out_vld); n_err++; end
    n_cmp++; if (out_res !== 32'h3F80_0000) begin $display("FAIL single_out_res got %h want 3f800000", out_res); n_err++; end
    n_cmp++; if (out_cls !== 4'b0000) begin $display("FAIL single_out_cls got %b want 0000", out_cls); n_err++; end
    n_cmp++; if (cnt !== 3'd1) begin $display("FAIL single_cnt got %0d want 1", cnt); n_err++; end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    n_cmp++; if (cnt !== 3'd0) begin $display("FAIL single_drain_cnt got %0d want 0", cnt); n_err++; end
  endtask

  task automatic test_classify();
    logic [31:0] v [4];
    logic [3:0]  c [4];
    v = '{32'h8000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
    c = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_res = v[i];
      step();
    end
    in_vld = 1'b0;
    n_cmp++; if (cnt !== 3'd4) begin $display("FAIL cls_fill_cnt got %0d want 4", cnt); n_err++; end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_cls !== c[i]) begin $display("FAIL cls_%0d got %b want %b", i, out_cls, c[i]); n_err++; end
      n_cmp++; if (out_res !== v[i]) begin $display("FAIL cls_res_%0d got %h want %h", i, out_res, v[i]); n_err++; end
      step();
    end
    out_rdy = 1'b0;
    n_cmp++; if (out_vld !== 1'b0) begin $display("FAIL cls_empty_vld got %b want 0", out_vld); n_err++; end
    n_cmp++; if (out_cls !== 4'b0000) begin $display("FAIL cls_empty_cls got %b want 0000", out_cls); n_err++; end
  endtask

  task automatic test_overflow();
    logic [31:0] v [5];
    logic [3:0]  c [4];
    v = '{32'h4000_0000, 32'h0000_0000, 32'hFF80_0000, 32'h807F_FFFF, 32'h7F80_0001};
    c = '{4'b0000, 4'b0001, 4'b0100, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_res = v[i];
      step();
      if (i == 3) begin
        n_cmp++; if (in_rdy !== 1'b0) begin $display("FAIL ovf_full_in_rdy got %b want 0", in_rdy); n_err++; end
        n_cmp++; if (ovf !== 1'b0) begin $display("FAIL ovf_early got %b want 0", ovf); n_err++; end
      end
    end
    in_vld = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin $display("FAIL ovf_set got %b want 1", ovf); n_err++; end
    n_cmp++; if (cnt !== 3'd4) begin $display("FAIL ovf_cnt got %0d want 4", cnt); n_err++; end
    step();
    n_cmp++; if (out_res !== v[0]) begin $display("FAIL ovf_hold got %h want %h", out_res, v[0]); n_err++; end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_res !== v[i]) begin $display("FAIL ovf_pop_%0d got %h want %h", i, out_res, v[i]); n_err++; end
      n_cmp++; if (out_cls !== c[i]) begin $display("FAIL ovf_pop_cls_%0d got %b want %b", i, out_cls, c[i]); n_err++; end
      step();
    end
    out_rdy = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin $display("FAIL ovf_sticky got %b want 1", ovf); n_err++; end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin $display("FAIL ovf_clr got %b want 0", ovf); n_err++; end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_res = 32'h4100_0000 + i;
      step();
    end
    in_res = 32'h4200_0000; out_rdy = 1'b1;
    step();
    in_vld = 1'b0; out_rdy = 1'b0;
    n_cmp++; if (cnt !== 3'd3) begin $display("FAIL fullpp_cnt got %0d want 3", cnt); n_err++; end
    n_cmp++; if (ovf !== 1'b1) begin $display("FAIL fullpp_ovf got %b want 1", ovf); n_err++; end
    n_cmp++; if (out_res !== 32'h4100_0001) begin $display("FAIL fullpp_head got %h want 41000001", out_res); n_err++; end
  endtask

  task automatic test_back_to_back();
    out_rdy = 1'b1;
    step();
    q = {32'h4100_0002, 32'h4100_0003};
    n_cmp++; if (cnt !== 3'd2) begin $display("FAIL b2b_start_cnt got %0d want 2", cnt); n_err++; end
    for (int i = 0; i < 10; i++) begin
      in_vld = 1'b1; in_res = 32'h4300_0000 + i;
      n_cmp++; if (out_res !== q[0]) begin $display("FAIL b2b_head_%0d got %h want %h", i, out_res, q[0]); n_err++; end
      step();
      void'(q.pop_front());
      q.push_back(32'h4300_0000 + i);
      n_cmp++; if (cnt !== 3'd2) begin $display("FAIL b2b_cnt_%0d got %0d want 2", i, cnt); n_err++; end
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    n_cmp++; if (out_res !== 32'h4300_0008) begin $display("FAIL b2b_final_head got %h want 43000008", out_res); n_err++; end
  endtask

  task automatic test_clr_race_and_reset();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    in_vld = 1'b1; in_res = 32'h4400_0000;
    step(); step();
    n_cmp++; if (cnt !== 3'd4) begin $display("FAIL race_fill_cnt got %0d want 4", cnt); n_err++; end
    n_cmp++; if (ovf !== 1'b0) begin $display("FAIL race_pre_ovf got %b want 0", ovf); n_err++; end
    step();
    n_cmp++; if (ovf !== 1'b1) begin $display("FAIL race_drop_ovf got %b want 1", ovf); n_err++; end
    ovf_clr = 1'b1;
    step();
    n_cmp++; if (ovf !== 1'b1) begin $display("FAIL race_set_wins got %b want 1", ovf); n_err++; end
    in_vld = 1'b0;
    step();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin $display("FAIL race_clear got %b want 0", ovf); n_err++; end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    n_cmp++; if (cnt !== 3'd3) begin $display("FAIL race_cnt3 got %0d want 3", cnt); n_err++; end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (cnt !== 3'd0) begin $display("FAIL midrst_cnt got %0d want 0", cnt); n_err++; end
    n_cmp++; if (out_vld !== 1'b0) begin $display("FAIL midrst_out_vld got %b want 0", out_vld); n_err++; end
    n_cmp++; if (out_res !== 32'h0) begin $display("FAIL midrst_out_res got %h want 0", out_res); n_err++; end
    n_cmp++; if (in_rdy !== 1'b1) begin $display("FAIL midrst_in_rdy got %b want 1", in_rdy); n_err++; end
    in_vld = 1'b1; in_res = 32'hC000_0000;
    step();
    in_vld = 1'b0;
    n_cmp++; if (out_res !== 32'hC000_0000) begin $display("FAIL postrst_head got %h want c0000000", out_res); n_err++; end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_classify();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clr_race_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
